// File: rtl/keypad_scan.sv
// Matrix keypad scanner: one-cold row drive, per-frame column sampling,
// press/release debouncing, multi-key rejection and single-cycle event strobes.
module keypad_scan #(
  parameter  int unsigned ROWS     = 4,
  parameter  int unsigned COLS     = 4,
  parameter  int unsigned SCAN_DIV = 65536,
  parameter  int unsigned DEBOUNCE = 4,
  localparam int unsigned CODE_W   = $clog2(ROWS * COLS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [COLS-1:0]   column_i,
  output logic [ROWS-1:0]   row_o,
  output logic [CODE_W-1:0] key_code_o,
  output logic              key_valid_o,
  output logic              key_held_o,
  output logic              key_release_o,
  output logic              multi_err_o
);

  localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
  localparam int unsigned RIDX_W = $clog2(ROWS);
  localparam int unsigned CIDX_W = $clog2(COLS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_REL_DB
  } state_e;

  state_e              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [RIDX_W-1:0]   row_idx_q;
  logic [ROWS-1:0]     row_q;
  logic [1:0]          hit_cnt_q;
  logic [CODE_W-1:0]   first_code_q;
  logic [CODE_W-1:0]   cand_q;
  logic [3:0]          stable_q;
  logic [3:0]          rel_q;
  logic [CODE_W-1:0]   key_code_q;
  logic                key_valid_q;
  logic                key_held_q;
  logic                key_release_q;
  logic                multi_err_q;

  logic                sample_c;
  logic                last_row_c;
  logic [RIDX_W-1:0]   next_idx_c;
  logic [1:0]          row_hits_c;
  logic [CIDX_W-1:0]   row_col_c;
  logic [CODE_W-1:0]   row_code_c;
  logic [1:0]          base_hits_c;
  logic [2:0]          hit_sum_c;
  logic [1:0]          frame_hits_c;
  logic [CODE_W-1:0]   frame_code_c;
  logic                frame_end_c;
  logic                is_key_c;
  logic                is_multi_c;
  logic                cand_match_c;
  logic [3:0]          stable_inc_c;
  logic [3:0]          rel_inc_c;

  assign sample_c   = (div_q == DIV_W'(SCAN_DIV - 1));
  assign last_row_c = (row_idx_q == RIDX_W'(ROWS - 1));
  assign next_idx_c = last_row_c ? '0 : row_idx_q + RIDX_W'(1);

  // Active contacts in the current row: count saturates at 2, lowest column wins.
  always_comb begin
    row_hits_c = 2'd0;
    row_col_c  = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!column_i[c]) begin
        row_col_c = CIDX_W'(c);
        if (row_hits_c != 2'd2) row_hits_c = row_hits_c + 2'd1;
      end
    end
  end

  assign row_code_c = CODE_W'(32'(row_idx_q) * COLS + 32'(row_col_c));

  // Row 0 starts a fresh frame, so the stored accumulators are ignored there.
  assign base_hits_c  = (row_idx_q == '0) ? 2'd0 : hit_cnt_q;
  assign hit_sum_c    = 3'(base_hits_c) + 3'(row_hits_c);
  assign frame_hits_c = (hit_sum_c >= 3'd2) ? 2'd2 : hit_sum_c[1:0];
  assign frame_code_c = (base_hits_c == 2'd0) ? row_code_c : first_code_q;

  assign frame_end_c  = sample_c && last_row_c;
  assign is_key_c     = frame_end_c && (frame_hits_c == 2'd1);
  assign is_multi_c   = frame_end_c && (frame_hits_c == 2'd2);
  assign cand_match_c = (frame_code_c == cand_q);

  assign stable_inc_c = (stable_q == 4'hF) ? 4'hF : stable_q + 4'd1;
  assign rel_inc_c    = (rel_q == 4'hF) ? 4'hF : rel_q + 4'd1;

  // Scan timing, frame accumulation and debounce FSM with registered strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      div_q         <= '0;
      row_idx_q     <= '0;
      row_q         <= ~ROWS'(1);
      hit_cnt_q     <= 2'd0;
      first_code_q  <= '0;
      cand_q        <= '0;
      stable_q      <= 4'd0;
      rel_q         <= 4'd0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
      multi_err_q   <= 1'b0;
    end else begin
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      multi_err_q   <= 1'b0;

      if (sample_c) begin
        div_q        <= '0;
        row_idx_q    <= next_idx_c;
        row_q        <= ~(ROWS'(1) << next_idx_c);
        hit_cnt_q    <= frame_hits_c;
        first_code_q <= frame_code_c;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end

      if (frame_end_c) begin
        multi_err_q <= is_multi_c;
        case (state_q)
          S_IDLE: begin
            if (is_key_c) begin
              cand_q   <= frame_code_c;
              stable_q <= 4'd1;
              if (DEBOUNCE == 1) begin
                key_code_q  <= frame_code_c;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                rel_q       <= 4'd0;
                state_q     <= S_HELD;
              end else begin
                state_q <= S_PRESS_DB;
              end
            end
          end
          S_PRESS_DB: begin
            if (!is_key_c) begin
              state_q <= S_IDLE;
            end else if (!cand_match_c) begin
              cand_q   <= frame_code_c;
              stable_q <= 4'd1;
            end else begin
              stable_q <= stable_inc_c;
              if (stable_inc_c == 4'(DEBOUNCE)) begin
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                rel_q       <= 4'd0;
                state_q     <= S_HELD;
              end
            end
          end
          S_HELD: begin
            if (is_key_c) begin
              rel_q <= 4'd0;
            end else if (DEBOUNCE == 1) begin
              key_release_q <= 1'b1;
              key_held_q    <= 1'b0;
              state_q       <= S_IDLE;
            end else begin
              rel_q   <= 4'd1;
              state_q <= S_REL_DB;
            end
          end
          S_REL_DB: begin
            if (is_key_c) begin
              rel_q <= 4'd0;
              if (cand_match_c) state_q <= S_HELD;
            end else begin
              rel_q <= rel_inc_c;
              if (rel_inc_c == 4'(DEBOUNCE)) begin
                key_release_q <= 1'b1;
                key_held_q    <= 1'b0;
                state_q       <= S_IDLE;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign row_o         = row_q;
  assign key_code_o    = key_code_q;
  assign key_valid_o   = key_valid_q;
  assign key_held_o    = key_held_q;
  assign key_release_o = key_release_q;
  assign multi_err_o   = multi_err_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad model drives the columns and
// expected event strobes are queued with their cycle and compared as they occur.
module tb_keypad_scan;

  localparam int unsigned FR = 16;
  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_REL   = 3'b010;
  localparam logic [2:0] K_MULTI = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [3:0]  code;
    int unsigned cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] column;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid, key_held, key_release, multi_err;

  logic [15:0] keys;
  int unsigned ecnt;
  int          passed = 0;
  int          total  = 0;
  ev_t         exp_q[$];
  ev_t         mon_e;

  always #5 clk = ~clk;

  keypad_scan #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .column_i(column), .row_o(row),
    .key_code_o(key_code), .key_valid_o(key_valid), .key_held_o(key_held),
    .key_release_o(key_release), .multi_err_o(multi_err)
  );

  // Pressed key at code r*4+c pulls column c low while row r is driven low.
  always_comb begin
    column = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) column[c] = 1'b0;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total = total + 1;
    assert (obs === expv) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic push_ev(input logic [2:0] kind, input logic [3:0] code, input int unsigned frame);
    ev_t e;
    e.kind = kind;
    e.code = code;
    e.cyc  = FR * (frame + 1);
    exp_q.push_back(e);
  endtask

  task automatic goto_cycle(input int unsigned t);
    while (ecnt < t) @(negedge clk);
  endtask

  // Every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && (key_valid || key_release || multi_err)) begin
      check("valid_rel_exclusive", 32'(key_valid & key_release), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({key_valid, key_release, multi_err}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", 32'({key_valid, key_release, multi_err}), 32'(mon_e.kind));
        check("event_code", 32'(key_code), 32'(mon_e.code));
        check("event_cycle", ecnt, mon_e.cyc);
        if (key_valid)   check("held_on_valid", 32'(key_held), 32'd1);
        if (key_release) check("held_on_release", 32'(key_held), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] er;
    rst_n = 1'b0;
    keys  = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_row", 32'(row), 32'h E);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_outs", 32'({key_valid, key_held, key_release, multi_err}), 32'd0);
    rst_n = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      goto_cycle(4 * i);
      er = ~(4'b0001 << (i % 4));
      check("row_rotate", 32'(row), 32'(er));
    end

    // Key 9 held for four frames, then released for four.
    push_ev(K_VALID, 4'd9, 3);
    goto_cycle(FR * 1);  keys = 16'h1 << 9;
    goto_cycle(FR * 4);
    check("held_key9", 32'(key_held), 32'd1);
    check("code_key9", 32'(key_code), 32'd9);
    goto_cycle(FR * 5);  keys = 16'h0;
    push_ev(K_REL, 4'd9, 7);
    goto_cycle(FR * 8);
    check("released_key9", 32'(key_held), 32'd0);
    check("retained_code9", 32'(key_code), 32'd9);

    // Bouncing key 5: one gap frame restarts the debounce.
    push_ev(K_VALID, 4'd5, 14);
    goto_cycle(FR * 9);  keys = 16'h1 << 5;
    goto_cycle(FR * 11); keys = 16'h0;
    goto_cycle(FR * 12); keys = 16'h1 << 5;
    goto_cycle(FR * 14);
    check("bounce_not_yet", 32'(key_held), 32'd0);
    goto_cycle(FR * 15); keys = 16'h0;
    check("held_key5", 32'(key_held), 32'd1);
    push_ev(K_REL, 4'd5, 17);
    goto_cycle(FR * 18);
    check("released_key5", 32'(key_held), 32'd0);

    // Keys 0 and 15 together, then 15 released.
    goto_cycle(FR * 19); keys = 16'h8001;
    push_ev(K_MULTI, 4'd5, 19);
    push_ev(K_MULTI, 4'd5, 20);
    push_ev(K_MULTI, 4'd5, 21);
    push_ev(K_VALID, 4'd0, 24);
    goto_cycle(FR * 22); keys = 16'h0001;
    check("multi_no_accept", 32'(key_held), 32'd0);
    goto_cycle(FR * 25);
    check("held_key0", 32'(key_held), 32'd1);
    check("code_key0", 32'(key_code), 32'd0);
    keys = 16'h0;
    push_ev(K_REL, 4'd0, 27);
    goto_cycle(FR * 28);
    check("released_key0", 32'(key_held), 32'd0);

    // Key 3 held, key 12 joins, 3 released: key 12 keeps clearing the release count.
    goto_cycle(FR * 29); keys = 16'h1 << 3;
    push_ev(K_VALID, 4'd3, 31);
    goto_cycle(FR * 32); keys = (16'h1 << 3) | (16'h1 << 12);
    push_ev(K_MULTI, 4'd3, 32);
    goto_cycle(FR * 33); keys = 16'h1 << 12;
    goto_cycle(FR * 35);
    check("held_rollover", 32'(key_held), 32'd1);
    check("code_rollover", 32'(key_code), 32'd3);

    // Reset mid-hold discards everything without a release strobe.
    goto_cycle(FR * 35 + 6);
    rst_n = 1'b0;
    #1;
    check("midrst_row", 32'(row), 32'hE);
    check("midrst_code", 32'(key_code), 32'd0);
    check("midrst_outs", 32'({key_valid, key_held, key_release, multi_err}), 32'd0);
    keys = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto_cycle(FR * 4);
    check("post_rst_held", 32'(key_held), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Parametrised matrix-keypad scanner with per-frame sampling, debouncing, multi-key rejection and press/release event pulses. It drives the keypad row lines and reads the column lines, then outputs a binary key code with single-cycle event strobes. It sits between the board keypad pins and the game/display logic, which consume key events instead of raw scan codes.

## Interface
- ROWS, 4, number of row lines driven (2..8)
- COLS, 4, number of column lines read (2..8)
- SCAN_DIV, 65536, clock cycles each row is held low (≥2)
- DEBOUNCE, 4, consecutive identical frames required to accept a press or a release (1..15)
- CODE_W, $clog2(ROWS*COLS), key code width (derived; not overridden)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- column  in  COLS  column lines, active-low, externally pulled up
- row  out  ROWS  row drive, exactly one bit low (one-cold)
- key_code  out  CODE_W  code of the last accepted key = row_idx*COLS + col_idx
- key_valid  out  1  one-cycle pulse: new press accepted, key_code updated the same cycle
- key_held  out  1  high from the key_valid cycle until the key_release cycle
- key_release  out  1  one-cycle pulse: held key released
- multi_err  out  1  one-cycle pulse: frame with two or more active contacts

## Operation
- Row scan: div counter 0..SCAN_DIV-1; row_idx 0..ROWS-1 wraps; row = ~(1<<row_idx).
- Sample: on the cycle div==SCAN_DIV-1, column is read for the current row (settled), then row_idx advances.
- Frame: ROWS consecutive samples starting at row_idx 0. Accumulates hit count (saturating at 2) and first hit code.
- Frame result, evaluated at the row ROWS-1 sample: NONE (0 hits), KEY(code) (exactly 1 hit), MULTI (≥2 hits, including two columns in one row). MULTI pulses multi_err and counts as NONE for debouncing.
- FSM states:
  - IDLE: KEY(c) -> PRESS_DB, cand=c, stable=1; if DEBOUNCE==1 accept immediately.
  - PRESS_DB: KEY(cand) -> stable+1; on stable==DEBOUNCE accept -> HELD. KEY(other) -> restart with cand=other, stable=1. NONE -> IDLE.
  - HELD: KEY(cand) -> stay, rel=0. NONE -> REL_DB, rel=1. KEY(other) -> ignored, rel=0 (rollover not supported).
  - REL_DB: NONE -> rel+1; on rel==DEBOUNCE -> IDLE with key_release. KEY(cand) -> HELD, rel=0. KEY(other) -> rel=0, stay.
- Accept: key_code<=cand, key_valid pulse, key_held<=1.
- Release: key_release pulse, key_held<=0, key_code retained.
- Counters stable/rel are 4-bit and saturate, never wrap.

## Timing
- Reset (async assert, synchronous release on clk): row = {ROWS-1{1},0}, div=0, row_idx=0, frame accumulators cleared, FSM IDLE, key_code=0, key_valid=0, key_held=0, key_release=0, multi_err=0.
- Reset asserted mid-debounce or in HELD: all state is discarded; no key_release is generated.
- Frame period = ROWS*SCAN_DIV cycles. The first frame after reset starts at cycle 0.
- key_valid, key_release and multi_err are registered and assert the cycle after the frame-end sample. They are never high for two consecutive cycles.
- Press latency: the press must be present by the sampled row's sample cycle. Accepted DEBOUNCE frames later, pulsing 1 cycle after that frame's end sample.
- Release latency: DEBOUNCE NONE frames after the last KEY frame.
- key_valid and key_release never assert in the same cycle. multi_err may coincide with a release-count frame.
- Columns change only matter on sample cycles; glitches between samples are invisible.

## Test plan
- ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3; reset -> row=4'b1110; outputs 0; row rotates 1110->1101->1011->0111->1110 every 4 cycles.
- Hold key row 2/col 1 (column=1101 while row=1011) for 4 frames -> single key_valid with key_code=9 at end of frame 3 +1 cycle; key_held=1.
- Release the key and hold it off for 3 frames -> key_release pulse at end of frame 3 +1 cycle; key_code stays 9; key_held=0.
- Bounce: key 5 present in frames 1 and 2, absent in 3, present in 4–6 -> exactly one key_valid, after frame 6, code 5.
- Press keys 0 and 15 together -> multi_err pulse every frame, no key_valid; then release 15 -> key 0 accepted after 3 frames.
- While key 3 is HELD, also press key 12, then release 3 only -> no new key_valid, key_release does not fire while key 12 frames keep resetting rel. Assert rst mid-HELD -> all outputs 0 immediately, no key_release.
